// File: rtl/bitwise_pkg.sv
// Shared types for the bitwise operations unit and its result collector.
// Contents:
//   BITWISE_WIDTH    default operand/result vector width
//   bitwise_result_t packed result word {and_red, or_red, or_v, and_v},
//                    with and_v in the low bits
//   pack_result      builds a bitwise_result_t from the four unit outputs
package bitwise_pkg;

    localparam int unsigned BITWISE_WIDTH = 3;

    typedef struct packed {
        logic                     and_red;
        logic                     or_red;
        logic [BITWISE_WIDTH-1:0] or_v;
        logic [BITWISE_WIDTH-1:0] and_v;
    } bitwise_result_t;

    function automatic bitwise_result_t pack_result(
        input logic [BITWISE_WIDTH-1:0] and_v,
        input logic [BITWISE_WIDTH-1:0] or_v,
        input logic                     or_red,
        input logic                     and_red
    );
        bitwise_result_t r;
        r.and_red = and_red;
        r.or_red  = or_red;
        r.or_v    = or_v;
        r.and_v   = and_v;
        return r;
    endfunction

endpackage

// File: rtl/bitwise_result_collector_if.sv
// Result handshake bus between the bitwise unit, the collector and its consumer.
// Signals:
//   in_valid / in_ready                           upstream handshake
//   in_and, in_or, in_or_red, in_and_red          upstream result fields
//   out_valid / out_ready                         downstream handshake
//   out_data                                      packed result word (2*WIDTH+2)
// Modports:
//   slave  : collector view (consumes in_*, produces out_*)
//   master : producer/consumer view (drives in_* and out_ready)
interface bitwise_result_collector_if
    import bitwise_pkg::*;
#(
    parameter int unsigned WIDTH = BITWISE_WIDTH
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_and;
    logic [WIDTH-1:0]   in_or;
    logic               in_or_red;
    logic               in_and_red;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH+1:0] out_data;

    modport slave (
        input  in_valid, in_and, in_or, in_or_red, in_and_red, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_and, in_or, in_or_red, in_and_red, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/bitwise_fifo.sv
// Generic synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst   clock, asynchronous active-high reset (pointers only)
//   push_i     write wdata_i (ignored when full)
//   pop_i      drop oldest entry (ignored when empty)
//   wdata_i    write data
//   rdata_o    oldest entry, valid while !empty_o
//   level_o    occupancy 0..DEPTH
//   full_o     level_o == DEPTH
//   empty_o    level_o == 0
module bitwise_fifo #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [DW-1:0]              wdata_i,
    output logic [DW-1:0]              rdata_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          push_ok, pop_ok;

    // Full/empty from pointer compare: same index, wrap bits differ => full.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Pointer advance; the AW+1 bit counter wraps the index DEPTH-1 -> 0.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; entries are only read once written.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
endmodule

// File: rtl/bitwise_result_collector.sv
// Collects bitwise-unit results into a FIFO and keeps saturating statistics.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   bus        bitwise_result_collector_if.slave handshake bus
//   stat_clr   synchronous clear of ones_cnt/zero_cnt (wins over increment)
//   level      FIFO occupancy
//   ones_cnt   accepted results with in_and_red=1 (saturating)
//   zero_cnt   accepted results with in_or_red=0 (saturating)
//   err        sticky consistency error
// Optional: define BITWISE_COLLECT_CHECK_EN to enable the consistency checker;
// otherwise err is tied low.
module bitwise_result_collector
    import bitwise_pkg::*;
#(
    parameter int unsigned WIDTH = BITWISE_WIDTH,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    bitwise_result_collector_if.slave   bus,
    input  logic                        stat_clr,
    output logic [$clog2(DEPTH):0]      level,
    output logic [CNT_W-1:0]            ones_cnt,
    output logic [CNT_W-1:0]            zero_cnt,
    output logic                        err
);
    localparam int unsigned DW = 2*WIDTH + 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             push, pop, full, empty;
    logic [DW-1:0]    wdata;
    logic [CNT_W-1:0] ones_cnt_q, ones_cnt_d;
    logic [CNT_W-1:0] zero_cnt_q, zero_cnt_d;

    // Ready/valid depend only on registered pointers, never on out_ready.
    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign push = bus.in_valid && !full;
    assign pop  = bus.out_ready && !empty;

    // Same layout as bitwise_result_t, written generically in WIDTH.
    assign wdata = {bus.in_and_red, bus.in_or_red, bus.in_or, bus.in_and};

    bitwise_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wdata),
        .rdata_o (bus.out_data),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );

    // Saturating statistics; clear has priority over an accepted push.
    always_comb begin
        ones_cnt_d = ones_cnt_q;
        zero_cnt_d = zero_cnt_q;
        if (stat_clr) begin
            ones_cnt_d = '0;
            zero_cnt_d = '0;
        end else if (push) begin
            if (bus.in_and_red && (ones_cnt_q != CNT_MAX))
                ones_cnt_d = ones_cnt_q + CNT_W'(1);
            if (!bus.in_or_red && (zero_cnt_q != CNT_MAX))
                zero_cnt_d = zero_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones_cnt_q <= '0;
            zero_cnt_q <= '0;
        end else begin
            ones_cnt_q <= ones_cnt_d;
            zero_cnt_q <= zero_cnt_d;
        end
    end

    assign ones_cnt = ones_cnt_q;
    assign zero_cnt = zero_cnt_q;

`ifdef BITWISE_COLLECT_CHECK_EN
    logic err_q, err_d, bad;

    // AND result must be a subset of OR, and and_red must match &in_and.
    always_comb begin
        bad   = ((bus.in_and & ~bus.in_or) != '0) ||
                (bus.in_and_red != (&bus.in_and));
        err_d = err_q || (push && bad);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_bitwise_result_collector.sv
module tb_bitwise_result_collector;
    import bitwise_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned CMAX  = 3;
`ifdef BITWISE_COLLECT_CHECK_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       stat_clr;
    logic [2:0] level;
    logic [1:0] ones_cnt, zero_cnt;
    logic       err;

    bitwise_result_collector_if #(.WIDTH(3)) bus();

    bitwise_result_collector #(
        .WIDTH (3),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .stat_clr (stat_clr),
        .level    (level),
        .ones_cnt (ones_cnt),
        .zero_cnt (zero_cnt),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    int unsigned exp_ones = 0;
    int unsigned exp_zero = 0;
    bit          exp_err  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle with scoreboard update; called at posedge+1.
    task automatic step(output bit acc);
        bit         do_pop, clr, orr, ar;
        logic [7:0] w;
`ifdef BITWISE_COLLECT_CHECK_EN
        bit bad;
        bad = ((bus.in_and & ~bus.in_or) != 3'b000) || (bus.in_and_red != (bus.in_and == 3'b111));
`endif
        check_eq("in_ready", 32'(bus.in_ready), 32'(exp_q.size() != DEPTH));
        check_eq("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) check_eq("out_data", 32'(bus.out_data), 32'(exp_q[0]));
        do_pop = bus.out_valid && bus.out_ready;
        acc    = bus.in_valid && bus.in_ready;
        w      = pack_result(bus.in_and, bus.in_or, bus.in_or_red, bus.in_and_red);
        clr    = stat_clr;
        orr    = bus.in_or_red;
        ar     = bus.in_and_red;
        @(posedge clk);
        #1;
        if (do_pop) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(w);
        if (clr) begin
            exp_ones = 0;
            exp_zero = 0;
        end else if (acc) begin
            if (ar && exp_ones < CMAX) exp_ones++;
            if (!orr && exp_zero < CMAX) exp_zero++;
        end
`ifdef BITWISE_COLLECT_CHECK_EN
        if (acc && bad) exp_err = 1'b1;
`endif
        check_eq("level", 32'(level), 32'(exp_q.size()));
        check_eq("ones_cnt", 32'(ones_cnt), 32'(exp_ones));
        check_eq("zero_cnt", 32'(zero_cnt), 32'(exp_zero));
        check_eq("err", 32'(err), 32'(exp_err));
    endtask

    task automatic send(input logic [2:0] a, input logic [2:0] o, input logic orr, input logic ar);
        bit acc = 1'b0;
        bus.in_and     = a;
        bus.in_or      = o;
        bus.in_or_red  = orr;
        bus.in_and_red = ar;
        bus.in_valid   = 1'b1;
        for (int i = 0; i < 40 && !acc; i++) step(acc);
        check_eq("send_accepted", 32'(acc), 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    // Asynchronous reset pulse between clock edges; called at posedge+1.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        exp_ones = 0;
        exp_zero = 0;
        exp_err  = 1'b0;
        check_eq("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("arst_level", 32'(level), 32'd0);
        check_eq("arst_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("arst_err", 32'(err), 32'd0);
        #1 rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        rst            = 1'b1;
        stat_clr       = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_and     = 3'b000;
        bus.in_or      = 3'b000;
        bus.in_or_red  = 1'b0;
        bus.in_and_red = 1'b0;
        bus.out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check_eq("rst_level", 32'(level), 32'd0);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("rst_ones", 32'(ones_cnt), 32'd0);
        check_eq("rst_zero", 32'(zero_cnt), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);

        // 1: single push, packing and one-cycle latency
        send(3'b001, 3'b111, 1'b1, 1'b0);
        check_eq("t1_valid", 32'(bus.out_valid), 32'd1);
        check_eq("t1_data", 32'(bus.out_data), 32'h79);
        check_eq("t1_level", 32'(level), 32'd1);
        bus.out_ready = 1'b1;
        idle(2);

        // 2: fill, hold a 5th word while full, then drain
        bus.out_ready = 1'b0;
        send(3'b001, 3'b011, 1'b1, 1'b0);
        send(3'b010, 3'b110, 1'b1, 1'b0);
        send(3'b111, 3'b111, 1'b1, 1'b1);
        send(3'b000, 3'b000, 1'b0, 1'b0);
        check_eq("t2_level_full", 32'(level), 32'd4);
        check_eq("t2_in_ready", 32'(bus.in_ready), 32'd0);
        bus.in_and = 3'b110; bus.in_or = 3'b111; bus.in_or_red = 1'b1; bus.in_and_red = 1'b0;
        bus.in_valid = 1'b1;
        step(acc); check_eq("t2_hold1", 32'(acc), 32'd0);
        step(acc); check_eq("t2_hold2", 32'(acc), 32'd0);
        bus.out_ready = 1'b1;
        step(acc); check_eq("t2_pop_no_push", 32'(acc), 32'd0);
        step(acc); check_eq("t2_5th_accept", 32'(acc), 32'd1);
        bus.in_valid = 1'b0;
        idle(6);

        // 3: simultaneous push/pop at level 2 across pointer wrap
        bus.out_ready = 1'b0;
        send(3'b011, 3'b111, 1'b1, 1'b0);
        send(3'b100, 3'b101, 1'b1, 1'b0);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_and = 3'b101; bus.in_or = 3'b101; bus.in_or_red = 1'b1; bus.in_and_red = 1'b0;
        step(acc); check_eq("t3_acc0", 32'(acc), 32'd1);
        bus.in_and = 3'b001; bus.in_or = 3'b001; bus.in_or_red = 1'b1; bus.in_and_red = 1'b0;
        step(acc); check_eq("t3_acc1", 32'(acc), 32'd1);
        bus.in_and = 3'b111; bus.in_or = 3'b111; bus.in_or_red = 1'b0; bus.in_and_red = 1'b1;
        step(acc); check_eq("t3_acc2", 32'(acc), 32'd1);
        bus.in_valid = 1'b0;
        check_eq("t3_level", 32'(level), 32'd2);
        idle(3);

        // 4: counter saturation and clear priority
        stat_clr = 1'b1;
        idle(1);
        stat_clr = 1'b0;
        for (int i = 0; i < 5; i++) send(3'b111, 3'b111, 1'b0, 1'b1);
        check_eq("t4_ones_sat", 32'(ones_cnt), 32'd3);
        check_eq("t4_zero_sat", 32'(zero_cnt), 32'd3);
        stat_clr = 1'b1;
        send(3'b111, 3'b111, 1'b0, 1'b1);
        stat_clr = 1'b0;
        check_eq("t4_ones_clr", 32'(ones_cnt), 32'd0);
        check_eq("t4_zero_clr", 32'(zero_cnt), 32'd0);
        idle(2);

        // 6: async reset mid-stream at level 3
        bus.out_ready = 1'b0;
        send(3'b001, 3'b011, 1'b1, 1'b0);
        send(3'b010, 3'b010, 1'b1, 1'b0);
        send(3'b100, 3'b110, 1'b1, 1'b0);
        check_eq("t6_level3", 32'(level), 32'd3);
        async_reset();
        send(3'b010, 3'b110, 1'b1, 1'b0);
        check_eq("t6_valid", 32'(bus.out_valid), 32'd1);
        check_eq("t6_data", 32'(bus.out_data), 32'h72);
        bus.out_ready = 1'b1;
        idle(2);

        // 5: consistency checker (sticky), then cleared only by reset
        send(3'b100, 3'b010, 1'b1, 1'b0);
        check_eq("t5_err_set", 32'(err), 32'(ERR_ON));
        for (int i = 0; i < 10; i++) send(3'b101, 3'b111, 1'b1, 1'b0);
        stat_clr = 1'b1;
        idle(1);
        stat_clr = 1'b0;
        check_eq("t5_err_sticky", 32'(err), 32'(ERR_ON));
        async_reset();
        check_eq("t5_err_rst", 32'(err), 32'd0);
        send(3'b011, 3'b011, 1'b1, 1'b1);
        check_eq("t5_err_andred", 32'(err), 32'(ERR_ON));
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bitwise_result_collector.md
Name: bitwise_result_collector

Overview:
- Downstream stage of the bitwise operations unit: consumes its per-operation results (vector AND, vector OR, OR-reduction of A, AND-reduction of the AND result).
- Packs each result into one word, buffers it in a small FIFO with valid/ready on both sides, and keeps saturating statistics counters.
- Lets a slower consumer (bus/debug readout) drain results without stalling the combinational unit's producer every cycle.

Parameters:
- WIDTH, 3, operand/result vector width; must match the bitwise unit.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_W, 8, width of each statistics counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream result valid.
- in_ready  out  1  collector can accept.
- in_and  in  WIDTH  vector AND result.
- in_or  in  WIDTH  vector OR result.
- in_or_red  in  1  OR-reduction of operand A.
- in_and_red  in  1  AND-reduction of the AND result.
- out_valid  out  1  out_data holds the oldest entry.
- out_ready  in  1  consumer accepts.
- out_data  out  2*WIDTH+2  packed word.
- level  out  $clog2(DEPTH)+1  current occupancy.
- stat_clr  in  1  synchronous clear of counters.
- ones_cnt  out  CNT_W  accepted results with in_and_red=1.
- zero_cnt  out  CNT_W  accepted results with in_or_red=0.
- err  out  1  sticky consistency error.

Behaviour:
- Reset (async, immediate): pointers=0, level=0, out_valid=0, in_ready=1, ones_cnt=0, zero_cnt=0, err=0. Storage is not cleared; contents are don't-care.
- Reset mid-stream discards all buffered entries immediately.
- Packing: out_data = {in_and_red, in_or_red, in_or, in_and}, with in_and at bits [WIDTH-1:0].
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (level != DEPTH), registered-state only. No combinational path from out_ready to in_ready; when full, a push is not accepted even if a pop occurs in the same cycle.
- out_valid = (level != 0). out_data = mem[rd_ptr] (first-word-fall-through from registered storage).
- Latency from push on empty FIFO to out_valid=1 is 1 cycle.
- Pointers: log2(DEPTH) index bits plus a wrap bit; full/empty are derived from pointer compare. Pointers wrap DEPTH-1 -> 0.
- Level update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop together (0 < level < DEPTH): level unchanged; order preserved.
  - Pop on empty, or push on full: cannot occur (qualified by valid/ready); state unchanged.
- Holding rule: upstream must hold in_* stable while in_valid=1 and in_ready=0. The collector does not check this.
- Counters update on push only:
  - ones_cnt increments if in_and_red=1.
  - zero_cnt increments if in_or_red=0.
  - Both saturate at 2^CNT_W-1 (no wrap).
  - stat_clr=1 forces both to 0 next edge; it wins over a simultaneous increment.
- No FSM beyond the FIFO occupancy: EMPTY (level 0), PARTIAL, FULL (level DEPTH), with transitions given by the level rules above.

Optional Feature:
- Macro: BITWISE_COLLECT_CHECK_EN.
- Defined: on each push, err is set if (in_and & ~in_or) != 0, or if in_and_red != &in_and. err is sticky until rst; stat_clr does not clear it.
- Undefined: checker logic is absent and err is tied 0. Port list is identical either way.

Decomposition:
- Shared package bitwise_pkg holds:
  - localparam default BITWISE_WIDTH=3;
  - packed-result typedef (and, or, or_red, and_red fields);
  - pack function.
- One sub-module, bitwise_fifo: generic synchronous FIFO with width/depth parameters, level, full/empty.
- Counters and checker stay in the top module.

Test Plan:
1. After reset, push in_and=001, in_or=111, in_or_red=1, in_and_red=0 -> next cycle out_valid=1, out_data=8'h79, level=1, ones_cnt=0, zero_cnt=0.
2. out_ready=0, push 4 distinct words -> level=4, in_ready=0; a 5th word held with in_valid=1 is not accepted. Then out_ready=1 -> 4 words out in push order, and the 5th is accepted on the first cycle in_ready returns to 1.
3. Level 2, push and pop in the same cycle for 3 cycles -> level stays 2, output sequence matches input order, no loss or duplication across pointer wrap.
4. CNT_W=2: push 5 words with in_and=111, in_and_red=1, in_or_red=0 -> ones_cnt=3, zero_cnt=3 (saturated). Then stat_clr=1 in the same cycle as a push -> both 0 next cycle.
5. With BITWISE_COLLECT_CHECK_EN:
   - push in_and=100, in_or=010 -> err=1 next cycle; err stays 1 through 10 clean pushes and stat_clr; err=0 only after rst.
   - separately, push in_and=011, in_and_red=1 -> err=1.
   - without the macro, the same stimulus gives err=0.
6. Level 3, assert rst asynchronously between edges -> out_valid=0, level=0, in_ready=1 before the next clock edge. After release, the first push reappears with 1-cycle latency.
